// File: rtl/mem_arbiter_pkg.sv
// Shared state encodings, port identifiers and helpers for the data memory arbiter.
package mem_arbiter_pkg;

    localparam int N_PORTS = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] PORT_LOADER = 2'd0;
    localparam logic [1:0] PORT_CPU    = 2'd1;
    localparam logic [1:0] PORT_DEBUG  = 2'd2;
    localparam logic [1:0] PORT_NONE   = 2'd3;

    function automatic logic [N_PORTS-1:0] port_onehot(input logic [1:0] p);
        logic [N_PORTS-1:0] oh;
        oh = '0;
        if (p != PORT_NONE) oh[p] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side bus of the arbiter: master = arbiter, slave = byte-wide data memory.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 8
);
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic          mem_read_en;
    logic          mem_write_en;
    logic          mem_ready;

    modport master (
        output mem_addr, mem_data_in, mem_read_en, mem_write_en,
        input  mem_data_out, mem_ready
    );

    modport slave (
        input  mem_addr, mem_data_in, mem_read_en, mem_write_en,
        output mem_data_out, mem_ready
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Fixed-priority (0 > 2 > 1) selector with boot-phase and cpu-halt eligibility gating.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic       boot_done,
    input  logic       cpu_halted,
    output logic       vld,
    output logic [1:0] idx
);
    logic [2:0] elig;

    assign elig[PORT_LOADER] = req[PORT_LOADER] & ~boot_done;
    assign elig[PORT_CPU]    = req[PORT_CPU]    &  boot_done;
    assign elig[PORT_DEBUG]  = req[PORT_DEBUG]  &  boot_done & cpu_halted;

    always_comb begin
        vld = |elig;
        idx = PORT_NONE;
        if (elig[PORT_LOADER])     idx = PORT_LOADER;
        else if (elig[PORT_DEBUG]) idx = PORT_DEBUG;
        else if (elig[PORT_CPU])   idx = PORT_CPU;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Three-port arbiter sequencing one transaction at a time onto the data memory.
// Optional WAIT watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int AW          = 32,
    parameter int DW          = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               boot_done,
    input  logic               cpu_halted,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   we,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]   done,
    output logic [DW-1:0]      rdata,
    output logic [1:0]         owner,
    output logic               err,
    mem_arbiter_if.master      mem
);
    state_t        state, state_nxt;
    logic          pick_vld;
    logic [1:0]    pick_idx;
    logic          timeout;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          rd_en_q, wr_en_q;

    logic [AW-1:0] addr_a  [N_REQ];
    logic [DW-1:0] wdata_a [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_a[g]  = addr[g*AW +: AW];
        assign wdata_a[g] = wdata[g*DW +: DW];
    end

    mem_arb_pick u_pick (
        .req        (req),
        .boot_done  (boot_done),
        .cpu_halted (cpu_halted),
        .vld        (pick_vld),
        .idx        (pick_idx)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    wait_cnt <= '0;
        else if (state == ST_ISSUE) wait_cnt <= '0;
        else if (state == ST_WAIT)  wait_cnt <= wait_cnt + CNT_W'(1);
    end

    assign timeout = (state == ST_WAIT) && !mem.mem_ready &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pick_vld) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (mem.mem_ready || timeout) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Enables are registered, so they rise on WAIT entry and fall on DONE entry,
    // leaving DONE/IDLE/ISSUE as a guaranteed idle gap between transactions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= PORT_NONE;
            err       <= 1'b0;
            rdata     <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
        end else begin
            if (boot_done && req[PORT_LOADER]) err <= 1'b1;
            case (state)
                ST_IDLE: if (pick_vld) begin
                    owner     <= pick_idx;
                    lat_we    <= we[pick_idx];
                    lat_addr  <= addr_a[pick_idx];
                    lat_wdata <= wdata_a[pick_idx];
                end
                ST_ISSUE: begin
                    addr_q  <= lat_addr;
                    data_q  <= lat_wdata;
                    rd_en_q <= !lat_we;
                    wr_en_q <= lat_we;
                end
                ST_WAIT: if (mem.mem_ready) begin
                    if (!lat_we) rdata <= mem.mem_data_out;
                    rd_en_q <= 1'b0;
                    wr_en_q <= 1'b0;
                end else if (timeout) begin
                    rdata   <= '1;
                    err     <= 1'b1;
                    rd_en_q <= 1'b0;
                    wr_en_q <= 1'b0;
                end
                ST_DONE: owner <= PORT_NONE;
                default: ;
            endcase
        end
    end

    assign done             = (state == ST_DONE) ? port_onehot(owner) : '0;
    assign mem.mem_addr     = addr_q;
    assign mem.mem_data_in  = data_q;
    assign mem.mem_read_en  = rd_en_q;
    assign mem.mem_write_en = wr_en_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a latency-programmable byte memory model.
module tb_mem_arbiter;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TCYC = 8;
`else
    localparam int TCYC = 64;
`endif

    typedef struct packed {
        logic [1:0] port;
        logic       is_rd;
        logic [7:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        boot_done, cpu_halted;
    logic [2:0]  req, we;
    logic [31:0] addr_a  [3];
    logic [7:0]  wdata_a [3];
    logic [95:0] addr_bus;
    logic [23:0] wdata_bus;
    logic [2:0]  done;
    logic [7:0]  rdata;
    logic [1:0]  owner;
    logic        err;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    int   lat = 1;
    logic never_ready = 1'b0;
    int   en_cnt = 0;
    logic [7:0] mem_m [logic [31:0]];

    int   wr_run = 0, last_wr_run = 0;
    int   rd_low = 0, last_rd_gap = 0;
    logic seen_rd = 1'b0;
    int   own0_cnt = 0;

    mem_arbiter_if #(.AW(32), .DW(8)) mif ();

    assign addr_bus  = {addr_a[2], addr_a[1], addr_a[0]};
    assign wdata_bus = {wdata_a[2], wdata_a[1], wdata_a[0]};

    mem_arbiter #(.N_REQ(3), .AW(32), .DW(8), .TIMEOUT_CYC(TCYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .boot_done  (boot_done),
        .cpu_halted (cpu_halted),
        .req        (req),
        .we         (we),
        .addr       (addr_bus),
        .wdata      (wdata_bus),
        .done       (done),
        .rdata      (rdata),
        .owner      (owner),
        .err        (err),
        .mem        (mif)
    );

    initial forever #5 clk = ~clk;

    // Memory model: ready after 'lat' enabled cycles; unwritten bytes read addr[7:0]^0x5A.
    assign mif.mem_ready = (mif.mem_read_en || mif.mem_write_en) && !never_ready &&
                           (en_cnt >= lat - 1);

    initial forever begin
        @(posedge clk);
        if (mif.mem_write_en && mif.mem_ready) mem_m[mif.mem_addr] = mif.mem_data_in;
        if ((mif.mem_read_en || mif.mem_write_en) && !mif.mem_ready) en_cnt <= en_cnt + 1;
        else en_cnt <= 0;
    end

    initial forever begin
        @(negedge clk);
        if (mem_m.exists(mif.mem_addr)) mif.mem_data_out = mem_m[mif.mem_addr];
        else mif.mem_data_out = mif.mem_addr[7:0] ^ 8'h5A;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and tracks enable timing.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (owner == 2'd0) own0_cnt++;
            if (mif.mem_write_en) wr_run++;
            else begin
                if (wr_run > 0) last_wr_run = wr_run;
                wr_run = 0;
            end
            if (mif.mem_read_en) begin
                if (seen_rd && rd_low > 0) last_rd_gap = rd_low;
                rd_low  = 0;
                seen_rd = 1'b1;
            end else rd_low++;
            if (done !== 3'b000) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: done=%b with nothing outstanding", done);
                end else begin
                    e = sb.pop_front();
                    chk("done_onehot", 32'(done), 32'(3'b001 << e.port));
                    chk("done_owner", 32'(owner), 32'(e.port));
                    if (e.is_rd) chk("rdata", 32'(rdata), 32'(e.rd));
                end
            end
        end
    end

    task automatic push(input logic [1:0] p, input logic r, input logic [7:0] d);
        exp_t e;
        e.port  = p;
        e.is_rd = r;
        e.rd    = d;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] p, input logic w, input logic [31:0] a,
                         input logic [7:0] d);
        we[p]      = w;
        addr_a[p]  = a;
        wdata_a[p] = d;
        req[p]     = 1'b1;
    endtask

    task automatic wait_done(input logic [1:0] p, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done[p]) break;
            if (cyc >= 300) begin
                n_tests++;
                n_fail++;
                $display("FAIL wait_done: port %0d no done after %0d cycles", p, cyc);
                break;
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_owner"}, 32'(owner), 32'd3);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_rd_en"}, 32'(mif.mem_read_en), 32'd0);
        chk({tag, "_wr_en"}, 32'(mif.mem_write_en), 32'd0);
        chk({tag, "_mem_addr"}, mif.mem_addr, 32'd0);
        chk({tag, "_mem_data_in"}, 32'(mif.mem_data_in), 32'd0);
    endtask

    initial begin
        int cyc;
        int snap;
        int k;
        rst = 1'b1; boot_done = 1'b0; cpu_halted = 1'b0;
        req = 3'b000; we = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr_a[i]  = 32'd0;
            wdata_a[i] = 8'd0;
        end
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst = 1'b0;
        @(negedge clk);

        // Loader write before boot: two-cycle memory latency.
        lat = 2;
        issue(2'd0, 1'b1, 32'h604, 8'h08);
        push(2'd0, 1'b0, 8'h00);
        wait_done(2'd0, cyc);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("wr_en_cycles", 32'(last_wr_run), 32'd2);
        chk("mem_0x604", 32'(mem_m[32'h604]), 32'h08);

        // Debug read-back after boot while cpu is halted.
        boot_done = 1'b1; cpu_halted = 1'b1; lat = 1;
        issue(2'd2, 1'b0, 32'h604, 8'h00);
        push(2'd2, 1'b1, 8'h08);
        wait_done(2'd2, cyc);
        req[2] = 1'b0;
        @(negedge clk);

        // cpu vs debug: cpu first while running, debug wins once halted.
        cpu_halted = 1'b0;
        issue(2'd1, 1'b0, 32'h20, 8'h00);
        issue(2'd2, 1'b0, 32'h604, 8'h00);
        push(2'd1, 1'b1, 8'h7A);
        push(2'd2, 1'b1, 8'h08);
        push(2'd1, 1'b1, 8'h7A);
        k = 0;
        while (owner != 2'd1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("cpu_granted_first", 32'(owner), 32'd1);
        cpu_halted = 1'b1;
        wait_done(2'd1, cyc);
        wait_done(2'd2, cyc);
        req[2] = 1'b0;
        wait_done(2'd1, cyc);
        req[1] = 1'b0;
        @(negedge clk);

        // Back-to-back cpu reads of the same address with req held.
        cpu_halted = 1'b0;
        issue(2'd1, 1'b0, 32'h10, 8'h00);
        push(2'd1, 1'b1, 8'h4A);
        push(2'd1, 1'b1, 8'h4A);
        wait_done(2'd1, cyc);
        chk("min_latency_cycles", 32'(cyc + 1), 32'd4);
        wait_done(2'd1, cyc);
        req[1] = 1'b0;
        chk("rd_gap_ge2", 32'(last_rd_gap >= 2), 32'd1);
        chk("err_still_clear", 32'(err), 32'd0);
        @(negedge clk);

        // Memory that never answers.
        never_ready = 1'b1;
        issue(2'd1, 1'b0, 32'h10, 8'h00);
`ifdef MEM_ARB_TIMEOUT_EN
        push(2'd1, 1'b1, 8'hFF);
        wait_done(2'd1, cyc);
        req[1] = 1'b0;
        @(negedge clk);
        chk("timeout_err", 32'(err), 32'd1);
        chk("timeout_rd_en_low", 32'(mif.mem_read_en), 32'd0);
        issue(2'd1, 1'b0, 32'h10, 8'h00);
        k = 0;
        while (!mif.mem_read_en && k < 10) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("wait_before_abort", 32'(mif.mem_read_en), 32'd1);
`else
        repeat (200) @(negedge clk);
        chk("stuck_rd_en", 32'(mif.mem_read_en), 32'd1);
        chk("stuck_owner", 32'(owner), 32'd1);
        chk("stuck_err", 32'(err), 32'd0);
`endif
        // Reset in the middle of WAIT aborts without a done pulse.
        req = 3'b000;
        rst = 1'b1;
        #1;
        chk_reset("abort");
        @(negedge clk);
        rst = 1'b0;
        never_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_abort_owner", 32'(owner), 32'd3);
        chk("post_abort_rd_en", 32'(mif.mem_read_en), 32'd0);

        // Loader requesting after boot: flagged, never granted, cpu unaffected.
        snap = own0_cnt;
        issue(2'd0, 1'b0, 32'h0, 8'h00);
        issue(2'd1, 1'b1, 32'h40, 8'h33);
        push(2'd1, 1'b0, 8'h00);
        wait_done(2'd1, cyc);
        req[1] = 1'b0;
        @(negedge clk);
        issue(2'd1, 1'b0, 32'h40, 8'h00);
        push(2'd1, 1'b1, 8'h33);
        wait_done(2'd1, cyc);
        req[1] = 1'b0;
        chk("loader_err_set", 32'(err), 32'd1);
        req[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("loader_never_owner", 32'(own0_cnt - snap), 32'd0);
        chk("err_sticky", 32'(err), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d outstanding", sb.size());
        $fatal(1, "watchdog");
    end
endmodule
